// File: rtl/bridge_pkg.sv
// Shared definitions for the APB command bridge: command/response entry
// layouts, sequencer state encoding and the decoded command record.
package bridge_pkg;

    localparam int CMD_W          = 73;
    localparam int CMD_WRITE_BIT  = 72;
    localparam int CMD_ADDR_LSB   = 40;
    localparam int CMD_ADDR_W     = 32;
    localparam int CMD_WDATA_LSB  = 8;
    localparam int CMD_WDATA_W    = 32;
    localparam int CMD_STRB_LSB   = 4;
    localparam int CMD_STRB_W     = 4;
    localparam int CMD_PROT_LSB   = 1;
    localparam int CMD_PROT_W     = 3;
    localparam int CMD_RSPREQ_BIT = 0;

    localparam int RSP_W          = 34;
    localparam int RSP_ERR_BIT    = 33;
    localparam int RSP_WRITE_BIT  = 32;
    localparam int RSP_DATA_LSB   = 0;
    localparam int RSP_DATA_W     = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} seq_state_t;

    typedef struct packed {
        logic                   write;
        logic [CMD_ADDR_W-1:0]  addr;
        logic [CMD_WDATA_W-1:0] wdata;
        logic [CMD_STRB_W-1:0]  strb;
        logic [CMD_PROT_W-1:0]  prot;
        logic                   rsp_req;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [CMD_W-1:0] e);
        cmd_t c;
        c.write   = e[CMD_WRITE_BIT];
        c.addr    = e[CMD_ADDR_LSB +: CMD_ADDR_W];
        c.wdata   = e[CMD_WDATA_LSB +: CMD_WDATA_W];
        c.strb    = e[CMD_STRB_LSB +: CMD_STRB_W];
        c.prot    = e[CMD_PROT_LSB +: CMD_PROT_W];
        c.rsp_req = e[CMD_RSPREQ_BIT];
        return c;
    endfunction

    // Reads always answer; writes only when the requester asked for it.
    function automatic logic needs_rsp(input cmd_t c);
        return !c.write || c.rsp_req;
    endfunction

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase cycle counter; expired_o flags the last permitted cycle.
module apb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Pops FWFT commands, runs each as an APB SETUP/ACCESS transfer and pushes
// read data or requested write completions into the response FIFO.
module apb_cmd_sequencer
    import bridge_pkg::*;
#(
    parameter int CMD_WIDTH      = 73,
    parameter int RSP_WIDTH      = 34,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 rclk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [CMD_WIDTH-1:0] cmd_rdata,
    input  logic                 cmd_r_empty,
    output logic                 cmd_ren,
    output logic [RSP_WIDTH-1:0] rsp_wdata,
    output logic                 rsp_wen,
    input  logic                 rsp_w_full,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [31:0]          paddr,
    output logic [31:0]          pwdata,
    output logic [3:0]           pstrb,
    output logic [2:0]           pprot,
    input  logic [31:0]          prdata,
    input  logic                 pready,
    input  logic                 pslverr,
    output logic                 busy,
    output logic                 timeout_flag,
    input  logic                 timeout_clr,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    seq_state_t           state_q;
    cmd_t                 head, cmd_q;
    logic                 psel_q, penable_q, rsp_wen_q, busy_q, timeout_q;
    logic [RSP_WIDTH-1:0] rsp_q, rsp_d;
    logic [CNT_WIDTH-1:0] xfer_q;
    logic                 wd_expired, pop, done, timed_out;

    assign head = decode_cmd(cmd_rdata);

    // Response space is reserved at pop time; nothing else writes that FIFO.
    assign pop = reset_n && (state_q == IDLE) && enable && !cmd_r_empty
                 && (!rsp_w_full || !needs_rsp(head));
    assign done      = (state_q == ACCESS) && (pready || wd_expired);
    assign timed_out = (state_q == ACCESS) && !pready && wd_expired;

    apb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk_i     (rclk),
        .rst_ni    (reset_n),
        .clr_i     (state_q != ACCESS),
        .en_i      (state_q == ACCESS),
        .expired_o (wd_expired)
    );

    always_comb begin
        rsp_d = '0;
        rsp_d[RSP_WRITE_BIT] = cmd_q.write;
        if (pready) begin
            rsp_d[RSP_ERR_BIT] = pslverr;
            if (!cmd_q.write) rsp_d[RSP_DATA_LSB +: RSP_DATA_W] = prdata;
        end else begin
            rsp_d[RSP_ERR_BIT] = 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rsp_wen_q <= 1'b0;
            busy_q    <= 1'b0;
            rsp_q     <= '0;
            timeout_q <= 1'b0;
            xfer_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    cmd_q   <= head;
                    psel_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: if (done) begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    rsp_q     <= rsp_d;
                    xfer_q    <= xfer_q + CNT_WIDTH'(1);
                    if (needs_rsp(cmd_q)) begin
                        rsp_wen_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RESP: begin
                    rsp_wen_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (timed_out) timeout_q <= 1'b1;
            else if (timeout_clr) timeout_q <= 1'b0;
        end
    end

    assign cmd_ren      = pop;
    assign psel         = psel_q;
    assign penable      = penable_q;
    assign pwrite       = cmd_q.write;
    assign paddr        = cmd_q.addr;
    assign pwdata       = cmd_q.wdata;
    assign pstrb        = cmd_q.strb;
    assign pprot        = cmd_q.prot;
    assign rsp_wen      = rsp_wen_q;
    assign rsp_wdata    = rsp_q;
    assign busy         = busy_q;
    assign timeout_flag = timeout_q;
    assign xfer_cnt     = xfer_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Bench for apb_cmd_sequencer: FIFO and APB slave models with a response scoreboard.
module tb_apb_cmd_sequencer;

    localparam int TO = 8;
    localparam int CW = 3;

    logic          rclk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [72:0]   cmd_rdata = '0;
    logic          cmd_r_empty = 1'b1;
    logic          cmd_ren;
    logic [33:0]   rsp_wdata;
    logic          rsp_wen;
    logic          rsp_w_full = 1'b0;
    logic          psel, penable, pwrite;
    logic [31:0]   paddr, pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [31:0]   prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic          busy, timeout_flag;
    logic          timeout_clr = 1'b0;
    logic [CW-1:0] xfer_cnt;

    apb_cmd_sequencer #(
        .CMD_WIDTH(73), .RSP_WIDTH(34), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .rclk(rclk), .reset_n(reset_n), .enable(enable),
        .cmd_rdata(cmd_rdata), .cmd_r_empty(cmd_r_empty), .cmd_ren(cmd_ren),
        .rsp_wdata(rsp_wdata), .rsp_wen(rsp_wen), .rsp_w_full(rsp_w_full),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .busy(busy),
        .timeout_flag(timeout_flag), .timeout_clr(timeout_clr), .xfer_cnt(xfer_cnt)
    );

    always #5 rclk = ~rclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [72:0] cq[$];
    logic [33:0] expq[$];
    int          pop_cyc[$];
    int          wait_n = 0;
    logic [31:0] rd_val = '0;
    logic        slv_err = 1'b0;
    int          acc_cnt = 0;
    int          last_acc_len = 0;
    int          n_pops = 0;
    int          n_rsp = 0;
    int          cyc = 0;
    int          exp_x = 0;
    logic        pop_s;
    logic [31:0] held_addr = '0;

    task automatic refresh();
        cmd_r_empty = (cq.size() == 0);
        cmd_rdata   = (cq.size() == 0) ? 73'h0 : cq[0];
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic rr);
        cq.push_back({w, a, d, s, 3'b010, rr});
        if (!w || rr) begin
            if (wait_n >= TO) expq.push_back({1'b1, w, 32'h0});
            else              expq.push_back({slv_err, w, (w ? 32'h0 : rd_val)});
        end
        refresh();
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge rclk);
            k++;
        end while (!(cq.size() == 0 && !busy && !cmd_ren && !rsp_wen) && k < 300);
        if (k >= 300) check_vec(tag, 0, 1);
    endtask

    // FWFT command FIFO: the head advances just after a popping edge.
    always @(posedge rclk) begin
        pop_s = cmd_ren;
        cyc++;
        #1;
        if (pop_s) begin
            void'(cq.pop_front());
            n_pops++;
            pop_cyc.push_back(cyc);
            refresh();
        end
    end

    // APB slave: pready after wait_n wait states of ACCESS.
    always @(posedge rclk) begin
        #1;
        if (psel && penable) begin
            pready = (acc_cnt == wait_n);
            acc_cnt++;
            last_acc_len = acc_cnt;
        end else begin
            pready  = 1'b0;
            acc_cnt = 0;
        end
        prdata  = rd_val;
        pslverr = slv_err;
    end

    always @(negedge rclk) begin
        if (rsp_wen) begin
            n_rsp++;
            if (expq.size() == 0) check_vec("rsp_unexpected", rsp_wdata, 0);
            else check_vec("rsp_entry", rsp_wdata, expq.pop_front());
        end
        if (cmd_ren && cmd_r_empty) check_vec("ren_while_empty", 1, 0);
        if (rsp_wen && rsp_w_full) check_vec("wen_while_full", 1, 0);
        if (psel && !penable) held_addr = paddr;
        else if (psel) check_vec("paddr_stable", paddr, held_addr);
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int n0;
        int r0;
        repeat (3) @(negedge rclk);
        check_vec("rst_ctrl", {psel, penable, cmd_ren, rsp_wen, busy, timeout_flag}, 0);
        check_vec("rst_cnt", xfer_cnt, 0);
        check_vec("rst_apb", {pwrite, paddr, pwdata, pstrb, pprot}, 0);
        check_vec("rst_rsp", rsp_wdata, 0);

        // Single write, no response
        enable = 1'b1;
        push_cmd(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
        #1 check_vec("rst_no_pop", cmd_ren, 0);
        @(negedge rclk) reset_n = 1'b1;
        #1 check_vec("t1_pop", {cmd_ren, psel}, 2'b10);
        @(negedge rclk);
        check_vec("t1_setup", {psel, penable, busy, cmd_ren}, 4'b1010);
        check_vec("t1_addr", {pwrite, paddr, pwdata}, {1'b1, 32'h40, 32'hDEADBEEF});
        @(negedge rclk);
        check_vec("t1_access", {psel, penable, busy}, 3'b111);
        check_vec("t1_strb_prot", {pstrb, pprot}, {4'hF, 3'b010});
        @(negedge rclk);
        check_vec("t1_done", {psel, penable, busy, rsp_wen}, 0);
        check_vec("t1_hold", paddr, 32'h40);
        check_vec("t1_pops", n_pops, 1);
        exp_x = 1;
        check_vec("t1_xfer", xfer_cnt, exp_x % 8);

        // Read with 3 wait states, then error responses
        wait_n = 3; rd_val = 32'h12345678; slv_err = 1'b0;
        push_cmd(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        #1 check_vec("t2_pop", {cmd_ren, psel}, 2'b10);
        wait_idle("t2_idle");
        check_vec("t2_acc_len", last_acc_len, 4);
        check_vec("t2_nrsp", n_rsp, 1);
        wait_n = 0; slv_err = 1'b1;
        push_cmd(1'b1, 32'h14, 32'hCAFE0001, 4'h3, 1'b1);
        rd_val = 32'h0BADF00D;
        push_cmd(1'b0, 32'h18, 32'h0, 4'h0, 1'b0);
        wait_idle("t2b_idle");
        slv_err = 1'b0;
        check_vec("t2_nrsp2", n_rsp, 3);
        exp_x = 4;
        check_vec("t2_xfer", xfer_cnt, exp_x % 8);

        // Response FIFO full holds off reads but not silent writes
        rsp_w_full = 1'b1; rd_val = 32'hA5A50001;
        push_cmd(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        #1 check_vec("t3_hold0", cmd_ren, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge rclk);
            check_vec("t3_hold", {cmd_ren, psel}, 0);
        end
        rsp_w_full = 1'b0;
        #1 check_vec("t3_release_pop", cmd_ren, 1);
        wait_idle("t3_idle");
        rsp_w_full = 1'b1;
        push_cmd(1'b1, 32'h24, 32'h55, 4'hF, 1'b0);
        #1 check_vec("t3_write_full_pop", cmd_ren, 1);
        wait_idle("t3b_idle");
        rsp_w_full = 1'b0;
        check_vec("t3_nrsp", n_rsp, 4);
        exp_x = 6;
        check_vec("t3_xfer", xfer_cnt, exp_x % 8);

        // Watchdog timeout and set-over-clear priority
        wait_n = 1000;
        push_cmd(1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
        wait_idle("t4_idle");
        check_vec("t4_acc_len", last_acc_len, TO);
        check_vec("t4_flag", timeout_flag, 1);
        check_vec("t4_nrsp", n_rsp, 5);
        exp_x = 7;
        check_vec("t4_xfer", xfer_cnt, exp_x % 8);
        timeout_clr = 1'b1;
        @(negedge rclk) timeout_clr = 1'b0;
        check_vec("t4_clr", timeout_flag, 0);
        push_cmd(1'b0, 32'h34, 32'h0, 4'h0, 1'b0);
        k = 0;
        do begin
            @(negedge rclk);
            k++;
        end while (!(penable && acc_cnt == TO) && k < 50);
        if (k >= 50) check_vec("t4_reach_timeout", 0, 1);
        timeout_clr = 1'b1;
        @(negedge rclk) timeout_clr = 1'b0;
        check_vec("t4_set_over_clr", timeout_flag, 1);
        wait_idle("t4b_idle");
        exp_x = 8;
        check_vec("t4_xfer_wrap", xfer_cnt, exp_x % 8);
        timeout_clr = 1'b1;
        @(negedge rclk) timeout_clr = 1'b0;
        wait_n = 0;

        // Back-to-back writes: one pop every 3 cycles
        pop_cyc.delete();
        n0 = n_pops;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'h100 + 32'(4 * i), 32'(i), 4'hF, 1'b0);
        wait_idle("t5_idle");
        check_vec("t5_pops", n_pops - n0, 4);
        for (int i = 1; i < 4; i++) check_vec("t5_spacing", pop_cyc[i] - pop_cyc[i-1], 3);
        exp_x = 12;
        check_vec("t5_xfer", xfer_cnt, exp_x % 8);

        // Enable dropped during the second transfer
        n0 = n_pops;
        for (int i = 0; i < 3; i++) push_cmd(1'b1, 32'h200 + 32'(4 * i), 32'(i), 4'hF, 1'b0);
        k = 0;
        do begin
            @(negedge rclk);
            k++;
        end while (n_pops - n0 < 2 && k < 30);
        enable = 1'b0;
        repeat (8) @(negedge rclk);
        check_vec("t5_en_pops", n_pops - n0, 2);
        check_vec("t5_en_left", cq.size(), 1);
        check_vec("t5_en_busy", busy, 0);
        enable = 1'b1;
        wait_idle("t5b_idle");
        check_vec("t5_en_pops3", n_pops - n0, 3);
        exp_x = 15;
        check_vec("t5_en_xfer", xfer_cnt, exp_x % 8);

        // Reset during ACCESS
        wait_n = 1000;
        push_cmd(1'b1, 32'h400, 32'h1, 4'hF, 1'b0);
        k = 0;
        do begin
            @(negedge rclk);
            k++;
        end while (!penable && k < 10);
        reset_n = 1'b0;
        @(negedge rclk);
        check_vec("t6_rst_ctrl", {psel, penable, busy, rsp_wen}, 0);
        check_vec("t6_rst_cnt", xfer_cnt, 0);
        wait_n = 0; rd_val = 32'h600D0001;
        r0 = n_rsp;
        push_cmd(1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
        #1 check_vec("t6_rst_no_pop", cmd_ren, 0);
        @(negedge rclk) reset_n = 1'b1;
        #1 check_vec("t6_pop", {cmd_ren, psel}, 2'b10);
        wait_idle("t6_idle");
        check_vec("t6_nrsp", n_rsp - r0, 1);
        check_vec("t6_xfer", xfer_cnt, 1);

        check_vec("scoreboard_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
